// File: rtl/vec_operand_loader.sv
// -----------------------------------------------------------------------------
// vec_operand_loader
//
// Fetches element pairs a[i], b[i] from a word-wide memory and writes them into
// the operand buffers of the vector adder. When all pairs are loaded it kicks
// the adder controller, waits for its sum_ready, then pulses done. Only one
// memory read is outstanding at any time, and a new pair is not started until
// both halves of the current one have returned.
//
// Parameters
//   ADDR_W  memory address width (byte addresses, word-aligned reads)
//   DATA_W  element / memory word width
//   IDX_W   element index width (same as the adder's len / cur_idx)
//
// Ports
//   clk          clock, all state updates on posedge
//   reset        synchronous active-low reset
//   start        load request, sampled only while idle
//   base_a       byte address of a[0]
//   base_b       byte address of b[0]
//   len          element count N (elements 0..N-1)
//   mem_read     read request, held until mem_resp
//   mem_address  word-aligned read address
//   mem_rdata    read data, valid with mem_resp
//   mem_resp     read completes this cycle
//   buf_we_a     write strobe into operand buffer a
//   buf_we_b     write strobe into operand buffer b
//   buf_idx      buffer write index
//   buf_wdata    buffer write data (pass-through of mem_rdata)
//   add_en       one-cycle start pulse to the adder controller
//   sum_ready    adder controller reports the sum is complete
//   busy         loader is not idle
//   done         one-cycle completion pulse
// -----------------------------------------------------------------------------
module vec_operand_loader #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [IDX_W-1:0]  len,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              buf_we_a,
  output logic              buf_we_b,
  output logic [IDX_W-1:0]  buf_idx,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              add_en,
  input  logic              sum_ready,
  output logic              busy,
  output logic              done
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_A     = 3'd1;
  localparam logic [2:0] S_RD_B     = 3'd2;
  localparam logic [2:0] S_KICK     = 3'd3;
  localparam logic [2:0] S_WAIT_SUM = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  logic [2:0]        state_q;
  logic [2:0]        state_d;

  // Transaction parameters captured at start; later changes on the inputs
  // have no effect on a load in progress.
  logic [ADDR_W-1:0] base_a_q;
  logic [ADDR_W-1:0] base_b_q;
  logic [IDX_W-1:0]  len_q;
  logic [IDX_W-1:0]  idx_q;

  logic              in_idle;
  logic              in_rd_a;
  logic              in_rd_b;
  logic              accept_a;
  logic              accept_b;
  logic              last_pair;
  logic [ADDR_W-1:0] rd_base;
  logic [ADDR_W-1:0] idx_offset;

  assign in_idle = (state_q == S_IDLE);
  assign in_rd_a = (state_q == S_RD_A);
  assign in_rd_b = (state_q == S_RD_B);

  // NOTE: the buffer strobes are combinational from mem_resp, so a response
  // landing in the same cycle reset is asserted would otherwise still write
  // the buffer before the state register falls back to idle. Qualifying with
  // reset keeps a dying transaction from corrupting the operands.
  assign accept_a = in_rd_a & mem_resp & reset;
  assign accept_b = in_rd_b & mem_resp & reset;

  // Index compare stays in IDX_W bits, so len = 2^IDX_W-1 ends at idx 2^IDX_W-2.
  // len = 0 never reaches the read states, so the wrap of len_q-1 is harmless.
  assign last_pair = (idx_q == (len_q - IDX_ONE));

  // Element i lives at base + 4*i; the sum wraps modulo 2^ADDR_W.
  assign idx_offset = ADDR_W'(idx_q) << 2;
  assign rd_base    = in_rd_b ? base_b_q : base_a_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so every path assigns it;
  // a missing default here is what turns a decoder into an inferred latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (len == '0) ? S_KICK : S_RD_A;
        end
      end
      S_RD_A: begin
        if (mem_resp) begin
          state_d = S_RD_B;
        end
      end
      S_RD_B: begin
        if (mem_resp) begin
          state_d = last_pair ? S_KICK : S_RD_A;
        end
      end
      S_KICK: begin
        state_d = S_WAIT_SUM;
      end
      S_WAIT_SUM: begin
        if (sum_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and transaction registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is sampled at the clock edge like any other input, and all
  // registered state uses non-blocking assignments so every register in this
  // block sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      base_a_q <= '0;
      base_b_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q <= state_d;
      if (in_idle && start) begin
        base_a_q <= base_a;
        base_b_q <= base_b;
        len_q    <= len;
        idx_q    <= '0;
      end else if (accept_b && !last_pair) begin
        // Advance only after the b half lands, so a and b share one index.
        idx_q <= idx_q + IDX_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_read    = in_rd_a | in_rd_b;
  assign mem_address = mem_read ? (rd_base + idx_offset) : '0;

  assign buf_we_a  = accept_a;
  assign buf_we_b  = accept_b;
  assign buf_idx   = idx_q;
  assign buf_wdata = (accept_a | accept_b) ? mem_rdata : '0;

  assign add_en = (state_q == S_KICK);
  assign busy   = ~in_idle;
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_vec_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_vec_operand_loader
//
// Directed bench for vec_operand_loader. A memory responder returns addr+1
// after a configurable number of wait cycles. A queue model lists, for each
// started load, the ordered reads and buffer writes the loader must produce;
// one compare process checks every cycle's address and buffer writes against
// it. Directed tasks check the cycle-level timing of add_en / done / busy, and
// literal checks on the captured buffer contents pin the model.
// -----------------------------------------------------------------------------
module tb_vec_operand_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_a;
  logic [31:0] base_b;
  logic [7:0]  len;
  logic        mem_read;
  logic [31:0] mem_address;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        buf_we_a;
  logic        buf_we_b;
  logic [7:0]  buf_idx;
  logic [31:0] buf_wdata;
  logic        add_en;
  logic        sum_ready;
  logic        busy;
  logic        done;

  vec_operand_loader #(
    .ADDR_W(32),
    .DATA_W(32),
    .IDX_W (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_a     (base_a),
    .base_b     (base_b),
    .len        (len),
    .mem_read   (mem_read),
    .mem_address(mem_address),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp),
    .buf_we_a   (buf_we_a),
    .buf_we_b   (buf_we_b),
    .buf_idx    (buf_idx),
    .buf_wdata  (buf_wdata),
    .add_en     (add_en),
    .sum_ready  (sum_ready),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fails  = 0;
  int n_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: ordered list of reads/writes every started load must produce
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        is_a;
    logic [7:0]  idx;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  function automatic void push_model(input logic [31:0] ba, input logic [31:0] bb,
                                     input logic [7:0] n);
    exp_t e;
    logic [31:0] a;
    for (int i = 0; i < int'(n); i++) begin
      a      = ba + 32'(i * 4);
      e.is_a = 1'b1; e.idx = 8'(i); e.addr = a; e.data = a + 32'd1;
      exp_q.push_back(e);
      a      = bb + 32'(i * 4);
      e.is_a = 1'b0; e.idx = 8'(i); e.addr = a; e.data = a + 32'd1;
      exp_q.push_back(e);
    end
  endfunction

  // What the operand buffers would hold, captured from the DUT's strobes.
  logic [31:0] buf_a_mem [256];
  logic [31:0] buf_b_mem [256];

  // ---------------------------------------------------------------------------
  // Memory responder: data = addr + 1 after wait_cfg wait cycles
  // ---------------------------------------------------------------------------
  int wait_cfg = 0;
  int wcnt     = 0;

  always @(posedge clk) begin
    #1;
    if (mem_read === 1'b1) begin
      if (wcnt >= wait_cfg) begin
        mem_resp  = 1'b1;
        mem_rdata = mem_address + 32'd1;
        wcnt      = 0;
      end else begin
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
        wcnt      = wcnt + 1;
      end
    end else begin
      mem_resp  = 1'b0;
      mem_rdata = 32'h0;
      wcnt      = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (mem_read === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_mem_read", {31'b0, mem_read}, 32'd0);
      else                   check("mem_address", mem_address, exp_q[0].addr);
    end
    if (reset === 1'b0) begin
      check("no_write_in_reset", {31'b0, buf_we_a | buf_we_b}, 32'd0);
    end else if (buf_we_a === 1'b1 || buf_we_b === 1'b1) begin
      n_writes++;
      check("write_only_on_resp", {31'b0, mem_resp & mem_read}, 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {31'b0, buf_we_a | buf_we_b}, 32'd0);
      end else begin
        cur = exp_q.pop_front();
        check("buf_we_a", {31'b0, buf_we_a}, {31'b0, cur.is_a});
        check("buf_we_b", {31'b0, buf_we_b}, {31'b0, ~cur.is_a});
        check("buf_idx", {24'b0, buf_idx}, {24'b0, cur.idx});
        check("buf_wdata", buf_wdata, cur.data);
      end
      if (buf_we_a === 1'b1) buf_a_mem[buf_idx] = buf_wdata;
      if (buf_we_b === 1'b1) buf_b_mem[buf_idx] = buf_wdata;
    end else if (mem_read === 1'b1 && mem_resp === 1'b1) begin
      check("write_on_resp", {31'b0, buf_we_a | buf_we_b}, 32'd1);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed transaction: start at edge k, expect add_en in cycle k+exp_off,
  // raise sum_ready sum_d cycles after add_en, expect done the cycle after.
  // Returns at the negedge of the done cycle, so the caller's next start
  // lands in the idle cycle directly following done.
  // ---------------------------------------------------------------------------
  task automatic run_txn(input logic [31:0] ba, input logic [31:0] bb, input logic [7:0] n,
                         input int wait_n, input int exp_off, input int sum_d);
    int off;
    int w0;
    w0 = n_writes;
    @(posedge clk); #2;
    wait_cfg = wait_n;
    base_a   = ba;
    base_b   = bb;
    len      = n;
    start    = 1'b1;
    push_model(ba, bb, n);
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", {31'b0, busy}, 32'd1);
    off = 1;
    while (add_en !== 1'b1 && off < 2000) begin
      @(negedge clk);
      off++;
    end
    check("add_en_cycle", off, exp_off);
    @(negedge clk);
    check("add_en_one_cycle", {31'b0, add_en}, 32'd0);
    check("busy_wait_sum", {31'b0, busy}, 32'd1);
    repeat (sum_d - 1) @(posedge clk);
    #2 sum_ready = 1'b1;
    @(negedge clk);
    check("done_before_sum_seen", {31'b0, done}, 32'd0);
    @(posedge clk); #2;
    sum_ready = 1'b0;
    @(negedge clk);
    check("done_pulse", {31'b0, done}, 32'd1);
    check("write_count", n_writes - w0, 2 * int'(n));
    check("model_drained", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_read"},    {31'b0, mem_read},  32'd0);
    check({tag, "_mem_address"}, mem_address,        32'd0);
    check({tag, "_buf_we_a"},    {31'b0, buf_we_a},  32'd0);
    check({tag, "_buf_we_b"},    {31'b0, buf_we_b},  32'd0);
    check({tag, "_buf_idx"},     {24'b0, buf_idx},   32'd0);
    check({tag, "_buf_wdata"},   buf_wdata,          32'd0);
    check({tag, "_add_en"},      {31'b0, add_en},    32'd0);
    check({tag, "_busy"},        {31'b0, busy},      32'd0);
    check({tag, "_done"},        {31'b0, done},      32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int seen;
    reset     = 1'b0;
    start     = 1'b0;
    base_a    = 32'h0;
    base_b    = 32'h0;
    len       = 8'd0;
    mem_rdata = 32'h0;
    mem_resp  = 1'b0;
    sum_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #2;
    reset = 1'b1;

    // Zero-wait, len=3: add_en at k+7.
    run_txn(32'h100, 32'h200, 8'd3, 0, 7, 2);
    check("t1_buf_a0", buf_a_mem[0], 32'h101);
    check("t1_buf_a1", buf_a_mem[1], 32'h105);
    check("t1_buf_a2", buf_a_mem[2], 32'h109);
    check("t1_buf_b0", buf_b_mem[0], 32'h201);
    check("t1_buf_b2", buf_b_mem[2], 32'h209);

    // Back-to-back start; start re-pulsed with a new base_a during RD_B.
    fork
      run_txn(32'h400, 32'h500, 8'd2, 0, 5, 2);
      begin
        seen = 0;
        for (int c = 0; c < 50 && seen == 0; c++) begin
          @(negedge clk);
          if (mem_read === 1'b1 && mem_address === 32'h500) seen = 1;
        end
        check("glitch_found_rd_b", seen, 32'd1);
        start  = 1'b1;
        base_a = 32'hDEAD_0000;
        len    = 8'd9;
        @(posedge clk); #2;
        start = 1'b0;
      end
    join
    check("t4_buf_a1_orig_base", buf_a_mem[1], 32'h405);
    @(negedge clk);
    check("idle_after_done_busy", {31'b0, busy}, 32'd0);
    check("idle_after_done_done", {31'b0, done}, 32'd0);
    check("idle_after_done_read", {31'b0, mem_read}, 32'd0);

    // Three wait cycles on every read, len=2: 4 reads of 4 cycles each.
    run_txn(32'h1000, 32'h2000, 8'd2, 3, 17, 3);
    check("t2_buf_b1", buf_b_mem[1], 32'h2005);

    // len=0: no reads, add_en at k+1, sum_ready at k+3, done at k+4.
    run_txn(32'h3000, 32'h4000, 8'd0, 0, 1, 2);

    // Address wrap on the a side.
    run_txn(32'hFFFF_FFFC, 32'h10, 8'd2, 0, 5, 2);
    check("wrap_buf_a0", buf_a_mem[0], 32'hFFFF_FFFD);
    check("wrap_buf_a1", buf_a_mem[1], 32'h0000_0001);
    check("wrap_buf_b1", buf_b_mem[1], 32'h15);

    // Maximum count.
    run_txn(32'h0, 32'h8000, 8'd255, 0, 511, 3);
    check("max_buf_a254", buf_a_mem[254], 32'h3F9);
    check("max_buf_b254", buf_b_mem[254], 32'h83F9);

    // Reset during RD_A with mem_resp in the reset cycle and the one after.
    @(posedge clk); #2;
    wait_cfg = 10;
    base_a   = 32'h300;
    base_b   = 32'h380;
    len      = 8'd2;
    start    = 1'b1;
    push_model(32'h300, 32'h380, 8'd2);
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    reset     = 1'b0;
    mem_resp  = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check("rst_mid_we_a", {31'b0, buf_we_a}, 32'd0);
    check("rst_mid_we_b", {31'b0, buf_we_b}, 32'd0);
    @(posedge clk); #2;
    reset     = 1'b1;
    mem_resp  = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    exp_q.delete();
    wait_cfg = 0;

    // Clean load after the aborted one, starting again from idx 0.
    run_txn(32'h600, 32'h700, 8'd2, 0, 5, 2);
    check("post_rst_buf_a0", buf_a_mem[0], 32'h601);
    check("post_rst_buf_b1", buf_b_mem[1], 32'h705);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
